// File: rtl/nabp_processing_scan_control.sv
// Scan sequencer for the processing-swappable datapath: walks every line of a partition
// and every scan position per line. Optional NABP_SCAN_PROFILE_EN adds busy/stall counters.
module nabp_processing_scan_control #(
  parameter int IMAGE_SIZE     = 256,
  parameter int PARTITION_SIZE = 32,
  parameter int SCAN_W         = 8,
  parameter int LINE_W         = 5,
  parameter int ANGLE_W        = 8,
  parameter int ANGLE_45       = 45,
  parameter int ANGLE_90       = 90,
  parameter int ANGLE_135      = 135,
  parameter int ANGLE_180      = 180
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               kick,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               stall,
  output logic               ready,
  output logic               err,
  output logic [ANGLE_W-1:0] active_angle,
  output logic               scan_mode,
  output logic               pe_en,
  output logic [SCAN_W-1:0]  scan_itr,
  output logic [LINE_W-1:0]  line_itr,
  output logic               line_start,
  output logic               line_done,
  output logic               done
`ifdef NABP_SCAN_PROFILE_EN
  ,
  output logic [31:0]        busy_cycles,
  output logic [31:0]        stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(IMAGE_SIZE - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(PARTITION_SIZE - 1);
  localparam logic [ANGLE_W-1:0] A45       = ANGLE_W'(ANGLE_45);
  localparam logic [ANGLE_W-1:0] A90       = ANGLE_W'(ANGLE_90);
  localparam logic [ANGLE_W-1:0] A135      = ANGLE_W'(ANGLE_135);
  localparam logic [ANGLE_W-1:0] A180      = ANGLE_W'(ANGLE_180);

  state_t              r_state;
  logic                r_desc;
  logic                r_ready;
  logic                r_err;
  logic [ANGLE_W-1:0]  r_active_angle;
  logic                r_scan_mode;
  logic                r_pe_en;
  logic [SCAN_W-1:0]   r_scan_itr;
  logic [LINE_W-1:0]   r_line_itr;
  logic                r_line_start;
  logic                r_line_done;
  logic                r_done;

  logic                w_angle_ok;
  logic                w_kick_desc;
  logic                w_kick_ymode;
  logic [SCAN_W-1:0]   w_start;
  logic [SCAN_W-1:0]   w_end;
  logic [SCAN_W-1:0]   w_next;
  logic                w_at_end;
  logic                w_last_line;

  assign w_angle_ok   = (angle < A180);
  assign w_kick_desc  = (angle >= A90);
  assign w_kick_ymode = (angle >= A45) && (angle < A135);

  assign w_start      = r_desc ? SCAN_LAST : '0;
  assign w_end        = r_desc ? '0 : SCAN_LAST;
  assign w_next       = r_desc ? (r_scan_itr - 1'b1) : (r_scan_itr + 1'b1);
  assign w_at_end     = (r_scan_itr == w_end);
  assign w_last_line  = (r_line_itr == LINE_LAST);

  // The visible scan_itr is always the last position handed to the PEs; a stall
  // holds it with pe_en low, and the step to the next position resumes afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_desc         <= 1'b0;
      r_ready        <= 1'b1;
      r_err          <= 1'b0;
      r_active_angle <= '0;
      r_scan_mode    <= 1'b0;
      r_pe_en        <= 1'b0;
      r_scan_itr     <= '0;
      r_line_itr     <= '0;
      r_line_start   <= 1'b0;
      r_line_done    <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; pulse outputs default low here and
      // are raised only by the branch that owns them, so no stale pulse survives a cycle.
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_line_start <= 1'b0;
      r_line_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (kick) begin
            if (w_angle_ok) begin
              r_state        <= S_SETUP;
              r_ready        <= 1'b0;
              r_active_angle <= angle;
              r_scan_mode    <= w_kick_ymode;
              r_desc         <= w_kick_desc;
              r_line_itr     <= '0;
              r_scan_itr     <= w_kick_desc ? SCAN_LAST : '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_SETUP, S_GAP: begin
          r_state      <= S_SCAN;
          r_pe_en      <= 1'b1;
          r_line_start <= 1'b1;
          r_line_done  <= w_at_end;
        end

        S_SCAN: begin
          if (stall) begin
            r_pe_en <= 1'b0;
          end else if (w_at_end) begin
            r_pe_en <= 1'b0;
            if (w_last_line) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_GAP;
              r_line_itr <= r_line_itr + 1'b1;
              r_scan_itr <= w_start;
            end
          end else begin
            r_pe_en     <= 1'b1;
            r_scan_itr  <= w_next;
            r_line_done <= (w_next == w_end);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_pe_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef NABP_SCAN_PROFILE_EN
  logic [31:0] r_busy_cycles;
  logic [31:0] r_stall_cycles;

  // Counters restart on an accepted kick and saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cycles  <= '0;
      r_stall_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (kick && w_angle_ok) begin
        r_busy_cycles  <= '0;
        r_stall_cycles <= '0;
      end
    end else begin
      if (r_busy_cycles != '1) begin
        r_busy_cycles <= r_busy_cycles + 32'd1;
      end
      if ((r_state == S_SCAN) && stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign busy_cycles  = r_busy_cycles;
  assign stall_cycles = r_stall_cycles;
`endif

  assign ready        = r_ready;
  assign err          = r_err;
  assign active_angle = r_active_angle;
  assign scan_mode    = r_scan_mode;
  assign pe_en        = r_pe_en;
  assign scan_itr     = r_scan_itr;
  assign line_itr     = r_line_itr;
  assign line_start   = r_line_start;
  assign line_done    = r_line_done;
  assign done         = r_done;

endmodule

// File: doc/nabp_processing_scan_control.md
# nabp_processing_scan_control

Sequencer for the processing-swappable datapath. On a kick carrying a projection angle, it walks every line of the current partition and, for each line, every scan position across the image. It drives the PE enable, scan mode, scan iterator and line iterator that the processing elements and the filtered-RAM address path consume. It sits between the host-side angle/kick interface and the PE array, and handles downstream back-pressure.

## Interface
Parameters:
- IMAGE_SIZE, 256, pixels per scan (N)
- PARTITION_SIZE, 32, lines per partition (P)
- SCAN_W, 8, width of scan_itr, must be ≥ clog2(N)
- LINE_W, 5, width of line_itr, must be ≥ clog2(P)
- ANGLE_W, 8, angle width; angle in whole degrees
- ANGLE_45 / ANGLE_90 / ANGLE_135 / ANGLE_180, 45/90/135/180, angle boundaries

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- kick  in  1  start request; sampled only in IDLE
- angle  in  ANGLE_W  projection angle, sampled with kick
- stall  in  1  downstream not ready; freezes scanning
- ready  out  1  high in IDLE
- err  out  1  one-cycle pulse when a kick carries angle ≥ ANGLE_180
- active_angle  out  ANGLE_W  latched angle
- scan_mode  out  1  0 = x-scan, 1 = y-scan
- pe_en  out  1  current scan_itr/line_itr are valid for the PEs
- scan_itr  out  SCAN_W  scan position
- line_itr  out  LINE_W  line within partition
- line_start  out  1  high with pe_en on the first position of each line
- line_done  out  1  high with pe_en on the last position of each line
- done  out  1  one-cycle pulse at end of partition

## Operation
- States: IDLE, SETUP, SCAN, GAP, DONE.
- IDLE: ready=1. On kick with angle < ANGLE_180, latch the angle and go to SETUP. On kick with angle ≥ ANGLE_180, pulse err next cycle and stay in IDLE.
- SETUP (1 cycle) sets scan mode and direction:
  - scan_mode = x if angle < ANGLE_45 or angle ≥ ANGLE_135, otherwise y.
  - Angle < ANGLE_90: ascending, start 0, end N-1. Otherwise descending, start N-1, end 0.
  - line_itr = 0, scan_itr = start.
- SCAN: pe_en = ~stall. On each non-stall cycle, scan_itr steps by ±1.
  - At end with no stall: line_done=1.
  - If line_itr == P-1, go to DONE; otherwise go to GAP.
- GAP (1 cycle): pe_en=0, line_itr += 1, scan_itr = start, then SCAN.
- DONE: done=1 for one cycle, then IDLE.
- kick outside IDLE is ignored; angle changes outside IDLE are ignored.
- stall outside SCAN has no effect. stall held indefinitely holds state with pe_en=0.
- Arithmetic: scan_itr never leaves 0..N-1 and line_itr never leaves 0..P-1. There is no modular wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE, ready=1, all other outputs 0.
- Reset asserted mid-operation aborts immediately to IDLE. No done pulse is produced.
- A kick sampled at edge k gives SETUP in cycle k+1 and the first pe_en in cycle k+2.
- With no stalls, partition latency from kick to done is 2 + P·N + (P-1) cycles. Each stalled SCAN cycle adds exactly 1.
- ready rises the cycle after done.
- A kick coincident with done is ignored.

## Configuration
- NABP_SCAN_PROFILE_EN defined:
  - Adds outputs busy_cycles[31:0] (cycles not in IDLE) and stall_cycles[31:0] (SCAN cycles with stall=1).
  - Both clear on an accepted kick, hold in IDLE, and saturate at all-ones.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
Settings: N=4, P=2.
- angle=30, no stall -> scan_mode=0; scan_itr 0,1,2,3 on line 0 (cycles 2–5); GAP at cycle 6; 0,1,2,3 on line 1 (cycles 7–10); done at cycle 11; ready at 12.
- angle=100 -> scan_mode=1, scan_itr 3,2,1,0 per line. angle=45 -> mode y, ascending. angle=135 -> mode x, descending.
- angle=30, stall high for 2 cycles when scan_itr=1 on line 0 -> pe_en=0 and scan_itr=1 held both cycles; done at cycle 13. With profile enabled: stall_cycles=2, busy_cycles=13.
- kick with angle=60 during SCAN -> ignored, active_angle unchanged. kick with angle=200 in IDLE -> err=1 for one cycle, ready stays 1, no pe_en.
- reset_n low while line_itr=1, scan_itr=2 -> outputs immediately at reset values. After release, a new kick runs a full partition normally.
- line_start and line_done markers -> each appears exactly P times per partition, coincident with pe_en at the start and end positions.
